// File: rtl/keypad_pkg.sv
// Shared constants, key vector type and helpers for the 4x4 keypad scanner.
// Key numbering is row-major: index = 4*row + col.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  function automatic int key_idx(input int row, input int col);
    return NUM_COLS * row + col;
  endfunction

  function automatic int unsigned conta_teclas(input key_vec_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// RESET_VAL should be the input's idle level so reset does not look like activity.
module sincronizador_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: sweeps columns, builds a full-matrix frame per sweep,
// and publishes the frame once DEBOUNCE_SCANS consecutive frames agree.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  linhas_n,
  output logic [3:0]  colunas_n,
  output logic [15:0] teclas,
  output logic        tecla_nova,
  output logic        conflito
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int RW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX     = RW'(DEBOUNCE_SCANS);

  logic [3:0]    w_linhas_sync;
  logic [1:0]    r_col;
  logic [SW-1:0] r_settle;
  logic [3:0]    r_colunas_n;
  key_vec_t      r_frame;
  key_vec_t      r_last;
  key_vec_t      r_teclas;
  logic [RW-1:0] r_run;
  logic          r_nova;
  logic          r_conf;

  key_vec_t      w_captured;
  key_vec_t      w_new;
  logic [RW-1:0] w_run_next;
  logic          w_sample;
  logic          w_frame_end;
  logic          w_update;

  sincronizador_2ff #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_sync_linhas (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(linhas_n),
    .o_sync (w_linhas_sync)
  );

  // Only the bits of the currently driven column are populated; rows are active-low.
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
      localparam int K = key_idx(gi, gj);
      assign w_captured[K] = (r_col == 2'(gj)) & ~w_linhas_sync[gi];
    end
  end

  assign w_sample    = (r_settle == SETTLE_LAST);
  assign w_frame_end = w_sample && (r_col == 2'd3);
  assign w_new       = r_frame | w_captured;

  always_comb begin
    w_run_next = RW'(1);
    if (w_new == r_last) begin
      w_run_next = (r_run == RUN_MAX) ? RUN_MAX : r_run + RW'(1);
    end
  end

  assign w_update = (w_run_next == RUN_MAX) && (w_new != r_teclas);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= 2'd0;
      r_settle    <= '0;
      r_colunas_n <= 4'b1110;
      r_frame     <= '0;
      r_last      <= '0;
      r_run       <= '0;
      r_teclas    <= '0;
      r_nova      <= 1'b0;
      r_conf      <= 1'b0;
    end else begin
      r_nova <= 1'b0;
      if (w_sample) begin
        r_settle    <= '0;
        r_col       <= r_col + 2'd1;
        r_colunas_n <= {r_colunas_n[2:0], r_colunas_n[3]};
        if (w_frame_end) begin
          r_frame <= '0;
          r_last  <= w_new;
          r_run   <= w_run_next;
          // Pulse only for keys that were not already published as pressed.
          if (w_update) begin
            r_teclas <= w_new;
            r_nova   <= |(w_new & ~r_teclas);
            r_conf   <= (conta_teclas(w_new) > 32'd1);
          end
        end else begin
          r_frame <= w_new;
        end
      end else begin
        r_settle <= r_settle + SW'(1);
      end
    end
  end

  assign colunas_n  = r_colunas_n;
  assign teclas     = r_teclas;
  assign tecla_nova = r_nova;
  assign conflito   = r_conf;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a frame-level keypad/debounce model predicts
// each teclas update; a negedge monitor pops and checks whenever the outputs move.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam logic [15:0] K6 = 16'h0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  linhas_n;
  logic [3:0]  colunas_n;
  logic [15:0] teclas;
  logic        tecla_nova;
  logic        conflito;
  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .linhas_n  (linhas_n),
    .colunas_n (colunas_n),
    .teclas    (teclas),
    .tecla_nova(tecla_nova),
    .conflito  (conflito)
  );

  // Passive matrix: a row is pulled low when a pressed key sits on a driven column.
  always_comb begin
    linhas_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !colunas_n[c]) linhas_n[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] t;
    logic        nova;
    logic        conf;
    int          frame;
  } exp_t;

  exp_t        q[$];
  logic [15:0] hist[$];
  logic [15:0] mdl_teclas = 16'h0000;
  int          mdl_frames = 0;

  function automatic int popc(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame seen by the scanner = each column's bits taken while that column was driven.
  task automatic model_frame(input logic [15:0] s0, s1, s2, s3);
    logic [15:0] f;
    int run;
    exp_t e;
    f = (s0 & 16'h1111) | (s1 & 16'h2222) | (s2 & 16'h4444) | (s3 & 16'h8888);
    hist.push_back(f);
    mdl_frames++;
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != f) break;
      run++;
    end
    if (run >= DEB && f != mdl_teclas) begin
      e.t     = f;
      e.nova  = |(f & ~mdl_teclas);
      e.conf  = (popc(f) > 1);
      e.frame = mdl_frames;
      q.push_back(e);
      mdl_teclas = f;
    end
  endtask

  // Monitor: column sweep shape, frame counting, and scoreboard pops on output activity.
  logic [3:0]  mon_prev_col;
  int          mon_age;
  bit          mon_first;
  int          mon_frames;
  logic [15:0] mon_prev_t;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_col = 4'b1110;
      mon_age      = 0;
      mon_first    = 1'b1;
      mon_frames   = 0;
      mon_prev_t   = 16'h0000;
    end else begin
      if (colunas_n != mon_prev_col) begin
        chk("col_seq", 32'(colunas_n), 32'({mon_prev_col[2:0], mon_prev_col[3]}));
        if (!mon_first) chk("col_len", 32'(mon_age), 32'(SETTLE));
        if (mon_prev_col == 4'b0111 && colunas_n == 4'b1110) mon_frames++;
        mon_first    = 1'b0;
        mon_age      = 1;
        mon_prev_col = colunas_n;
      end else begin
        mon_age++;
      end
      if (teclas !== mon_prev_t || tecla_nova !== 1'b0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_update: teclas=%h nova=%b conflito=%b, no update expected",
                   teclas, tecla_nova, conflito);
        end else begin
          mon_e = q.pop_front();
          chk("teclas", 32'(teclas), 32'(mon_e.t));
          chk("tecla_nova", 32'(tecla_nova), 32'(mon_e.nova));
          chk("conflito", 32'(conflito), 32'(mon_e.conf));
          chk("update_frame", 32'(mon_frames), 32'(mon_e.frame));
          $display("update frame=%0d teclas=%h nova=%b conflito=%b", mon_frames, teclas,
                   tecla_nova, conflito);
        end
        mon_prev_t = teclas;
      end
    end
  end

  logic [3:0] drv_prev;
  bit         fresh;

  task automatic wait_col(input int c);
    logic [3:0] tgt;
    tgt = ~(4'b0001 << c);
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (colunas_n != drv_prev) begin
        drv_prev = colunas_n;
        if (colunas_n == tgt) return;
      end
    end
    total++;
    bad++;
    $display("FAIL col_timeout: column %0d never driven, colunas_n=%b", c, colunas_n);
  endtask

  // Each column slot's key state is applied as that column starts being driven.
  task automatic drive_frame(input logic [15:0] s0, s1, s2, s3);
    if (fresh) fresh = 1'b0;
    else wait_col(0);
    keys = s0;
    wait_col(1);
    keys = s1;
    wait_col(2);
    keys = s2;
    wait_col(3);
    keys = s3;
    model_frame(s0, s1, s2, s3);
  endtask

  task automatic hold(input logic [15:0] k, input int n);
    repeat (n) drive_frame(k, k, k, k);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    drv_prev = 4'b1110;
    fresh    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base, s0, s1, s2, s3;
    int len;

    rst_n = 1'b0;
    keys  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_teclas", 32'(teclas), 32'h0);
    chk("rst_colunas", 32'(colunas_n), 32'he);
    chk("rst_nova", 32'(tecla_nova), 32'h0);
    chk("rst_conflito", 32'(conflito), 32'h0);
    release_reset();

    hold(16'h0000, 3);                        // idle sweep, no updates
    hold(K6, 3);                              // single key, pulse on 3rd frame
    hold(16'h0000, 3);                        // release-only update
    drive_frame(K6, K6, K6, K6);              // bounce: column-2 sample drops key 6
    drive_frame(K6, K6, 16'h0000, K6);
    hold(K6, 3);
    hold(16'h0041, 3);                        // two keys: conflito
    hold(K6, 3);                              // release key 0: no pulse
    hold(16'h0000, 3);
    hold(K6, 3);

    // Asynchronous reset in the middle of column 2 with teclas published.
    wait_col(0);
    wait_col(1);
    wait_col(2);
    @(posedge clk);
    #2;
    chk("pre_rst_teclas", 32'(teclas), 32'(K6));
    chk("pre_rst_queue", 32'(q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_teclas", 32'(teclas), 32'h0);
    chk("mid_rst_colunas", 32'(colunas_n), 32'he);
    chk("mid_rst_nova", 32'(tecla_nova), 32'h0);
    chk("mid_rst_conflito", 32'(conflito), 32'h0);
    hist.delete();
    mdl_teclas = 16'h0000;
    mdl_frames = 0;
    repeat (2) @(negedge clk);
    release_reset();
    hold(K6, 3);

    // Randomized holds with occasional single-slot glitches.
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       base = 16'h0000;
        1:       base = 16'(1) << $urandom_range(0, 15);
        2:       base = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: base = 16'($urandom);
      endcase
      len = $urandom_range(1, 5);
      for (int f = 0; f < len; f++) begin
        s0 = base; s1 = base; s2 = base; s3 = base;
        if ($urandom_range(0, 5) == 0) s0 = base ^ (16'(1) << $urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) s1 = base ^ (16'(1) << $urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) s2 = base ^ (16'(1) << $urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) s3 = base ^ (16'(1) << $urandom_range(0, 15));
        drive_frame(s0, s1, s2, s3);
      end
    end

    hold(16'h0000, 4);
    repeat (20) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_teclas", 32'(teclas), 32'(mdl_teclas));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
